// File: rtl/bram_delay.sv
// rtl/bram_delay.sv - four-line column delay (taps pa..pe) built from cascaded line buffers
// BRAM_DELAY_OUTREG_EN adds one output register stage (latency 3 instead of 2)
module bram_delay #(
    parameter int DATA_W   = 8,
    parameter int STAT_W   = 1,
    parameter int ADDR_W   = 12,
    parameter int LINE_LEN = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic [STAT_W-1:0] stat_in,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] pa,
    output logic [DATA_W-1:0] pb,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] pd,
    output logic [DATA_W-1:0] pe,
    output logic [STAT_W-1:0] stat_o
);
    localparam int IDX_W = $clog2(LINE_LEN);
    localparam int LBW   = DATA_W + STAT_W;

    logic [DATA_W-1:0] d1;
    logic [STAT_W-1:0] s1;
    logic [IDX_W-1:0]  a1;
    logic [IDX_W-1:0]  a2;

    logic [LBW-1:0]    lb1 [LINE_LEN] = '{default: '0};
    logic [LBW-1:0]    lb2 [LINE_LEN] = '{default: '0};
    logic [DATA_W-1:0] lb3 [LINE_LEN] = '{default: '0};
    logic [DATA_W-1:0] lb4 [LINE_LEN] = '{default: '0};

    logic [LBW-1:0]    q1;
    logic [LBW-1:0]    q2;
    logic [DATA_W-1:0] q3;
    logic [DATA_W-1:0] q4;
    logic [DATA_W-1:0] pe_r;

    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[ADDR_W-1:IDX_W];

    // Downstream buffers write one cycle after they are read, at the delayed address,
    // so each buffer receives the previous buffer's read data for the same column.
    always_ff @(posedge clk) begin
        lb1[a1] <= {d1, s1};
        lb2[a2] <= q1;
        lb3[a2] <= q2[LBW-1:STAT_W];
        lb4[a2] <= q3;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            d1   <= '0;
            s1   <= '0;
            a1   <= '0;
            a2   <= '0;
            pe_r <= '0;
            q1   <= '0;
            q2   <= '0;
            q3   <= '0;
            q4   <= '0;
        end else begin
            d1   <= data_in;
            s1   <= stat_in;
            a1   <= addr[IDX_W-1:0];
            a2   <= a1;
            pe_r <= d1;
            q1   <= lb1[a1];
            q2   <= lb2[a1];
            q3   <= lb3[a1];
            q4   <= lb4[a1];
        end
    end

`ifdef BRAM_DELAY_OUTREG_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            pa     <= '0;
            pb     <= '0;
            pc     <= '0;
            pd     <= '0;
            pe     <= '0;
            stat_o <= '0;
        end else begin
            pa     <= q4;
            pb     <= q3;
            pc     <= q2[LBW-1:STAT_W];
            pd     <= q1[LBW-1:STAT_W];
            pe     <= pe_r;
            stat_o <= q2[STAT_W-1:0];
        end
    end
`else
    assign pa     = q4;
    assign pb     = q3;
    assign pc     = q2[LBW-1:STAT_W];
    assign pd     = q1[LBW-1:STAT_W];
    assign pe     = pe_r;
    assign stat_o = q2[STAT_W-1:0];
`endif

endmodule

// File: tb/tb_bram_delay.sv
// tb/tb_bram_delay.sv - scoreboard bench for bram_delay with a per-column line-history model
module tb_bram_delay;
    localparam int L = 1024;
`ifdef BRAM_DELAY_OUTREG_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  data_in = '0;
    logic [0:0]  stat_in = '0;
    logic [11:0] addr = '0;
    logic [7:0]  pa, pb, pc, pd, pe;
    logic [0:0]  stat_o;

    bram_delay #(.DATA_W(8), .STAT_W(1), .ADDR_W(12), .LINE_LEN(L)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .stat_in(stat_in), .addr(addr),
        .pa(pa), .pb(pb), .pc(pc), .pd(pd), .pe(pe), .stat_o(stat_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] pe, pd, pc, pb, pa;
        logic       st;
        bit         vd, vc, vb, va, vs;
    } exp_t;

    exp_t sb[$];
    int   wq[$];

    // column history: m1 = last line written at a column, m4 = four lines back
    logic [7:0] m1 [L], m2 [L], m3 [L], m4 [L];
    logic       ms1 [L], ms2 [L];
    bit         v1 [L], v2 [L], v3 [L], v4 [L], vs1 [L], vs2 [L];

    int n_pass = 0, n_total = 0, cyc = 0, prev_col = 0;
    int sp_w = 2, sp_cnt = 0, run = 0, first_in = -1, first_out = -1, pulses_seen = 0;
    bit sp_hi = 1'b1, sp_done = 1'b0;

    task automatic drive_cycle(input logic [7:0] d, input logic [11:0] a, input logic r);
        exp_t e;
        logic st;
        int   c;
        int   cols [3];
        @(negedge clk);
        cyc++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_total++;
            if (pe === e.pe) n_pass++;
            else $display("FAIL pe cyc=%0d got=%h exp=%h", cyc, pe, e.pe);
            if (e.vd) begin
                n_total++;
                if (pd === e.pd) n_pass++;
                else $display("FAIL pd cyc=%0d got=%h exp=%h", cyc, pd, e.pd);
            end
            if (e.vc) begin
                n_total++;
                if (pc === e.pc) n_pass++;
                else $display("FAIL pc cyc=%0d got=%h exp=%h", cyc, pc, e.pc);
            end
            if (e.vb) begin
                n_total++;
                if (pb === e.pb) n_pass++;
                else $display("FAIL pb cyc=%0d got=%h exp=%h", cyc, pb, e.pb);
            end
            if (e.va) begin
                n_total++;
                if (pa === e.pa) n_pass++;
                else $display("FAIL pa cyc=%0d got=%h exp=%h", cyc, pa, e.pa);
            end
            if (e.vs) begin
                n_total++;
                if (stat_o[0] === e.st) n_pass++;
                else $display("FAIL stat_o cyc=%0d got=%b exp=%b", cyc, stat_o[0], e.st);
            end
        end
        if (stat_o[0] === 1'b1) begin
            run++;
            if (first_out < 0) first_out = cyc;
        end else if (run > 0) begin
            n_total++;
            if (wq.size() > 0 && wq[0] == run) n_pass++;
            else $display("FAIL pulse_width cyc=%0d got=%0d exp=%0d", cyc, run,
                          (wq.size() > 0) ? wq[0] : -1);
            if (wq.size() > 0) void'(wq.pop_front());
            pulses_seen++;
            run = 0;
        end

        st = 1'b0;
        if (r && !sp_done) begin
            if (sp_hi) begin
                st = 1'b1;
                if (first_in < 0) first_in = cyc;
                sp_cnt++;
                if (sp_cnt == sp_w) begin
                    sp_hi  = 1'b0;
                    sp_cnt = 0;
                    wq.push_back(sp_w);
                end
            end else begin
                sp_cnt++;
                if (sp_cnt == 2) begin
                    sp_cnt = 0;
                    sp_w += 2;
                    if (sp_w > 498) sp_done = 1'b1;
                    else sp_hi = 1'b1;
                end
            end
        end

        data_in = d;
        addr    = a;
        rst     = r;
        stat_in = st;
        c = int'(a[9:0]);
        if (!r) begin
            sb.delete();
            for (int i = 0; i < LAT - 1; i++) begin
                e = '{pe: 8'h00, pd: 8'h00, pc: 8'h00, pb: 8'h00, pa: 8'h00, st: 1'b0,
                      vd: 1'b1, vc: 1'b1, vb: 1'b1, va: 1'b1, vs: 1'b1};
                sb.push_back(e);
            end
            e = '{pe: 8'h00, pd: 8'h00, pc: 8'h00, pb: 8'h00, pa: 8'h00, st: 1'b0,
                  vd: 1'b0, vc: 1'b0, vb: 1'b0, va: 1'b0, vs: 1'b0};
            sb.push_back(e);
            // columns in flight around a reset edge lose their history
            cols = '{prev_col, c, 0};
            for (int k = 0; k < 3; k++) begin
                v1[cols[k]] = 1'b0; v2[cols[k]] = 1'b0; v3[cols[k]] = 1'b0;
                v4[cols[k]] = 1'b0; vs1[cols[k]] = 1'b0; vs2[cols[k]] = 1'b0;
            end
        end else begin
            e = '{pe: d, pd: m1[c], pc: m2[c], pb: m3[c], pa: m4[c], st: ms2[c],
                  vd: v1[c], vc: v2[c], vb: v3[c], va: v4[c], vs: vs2[c]};
            sb.push_back(e);
            m4[c] = m3[c]; v4[c] = v3[c];
            m3[c] = m2[c]; v3[c] = v2[c];
            m2[c] = m1[c]; v2[c] = v1[c];
            m1[c] = d;     v1[c] = 1'b1;
            ms2[c] = ms1[c]; vs2[c] = vs1[c];
            ms1[c] = st;     vs1[c] = 1'b1;
        end
        prev_col = c;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive_cycle(8'h00, 12'd0, 1'b0);
        n_total++;
        if (pe === 8'h00 && pd === 8'h00 && pc === 8'h00 && pb === 8'h00 && pa === 8'h00 &&
            stat_o === 1'b0) n_pass++;
        else $display("FAIL reset_state got=%h %h %h %h %h %b exp=all zero", pa, pb, pc, pd, pe, stat_o);
    endtask

    task automatic test_ramp();
        int t = 0;
        for (int ln = 0; ln < 5; ln++)
            for (int col = 0; col < L; col++) begin
                drive_cycle(8'(t), 12'(col), 1'b1);
                t++;
                if (ln == 4 && col == 100 + LAT) begin
                    n_total++;
                    if (pa === 8'd100 && pc === 8'd100 && pe === 8'd100) n_pass++;
                    else $display("FAIL ramp_taps got pa=%h pc=%h pe=%h exp=64", pa, pc, pe);
                end
            end
    endtask

    task automatic test_marker();
        logic [7:0] obs;
        for (int ln = 0; ln < 5; ln++)
            for (int col = 0; col < L; col++) begin
                drive_cycle((ln == 0 && col == 17) ? 8'hA5 : 8'h00, 12'(col), 1'b1);
                if (col == 17 + LAT) begin
                    case (ln)
                        0: obs = pe;
                        1: obs = pd;
                        2: obs = pc;
                        3: obs = pb;
                        default: obs = pa;
                    endcase
                    n_total++;
                    if (obs === 8'hA5) n_pass++;
                    else $display("FAIL marker line=%0d got=%h exp=a5", ln, obs);
                end
            end
    endtask

    task automatic test_alias();
        for (int col = 0; col < L; col++)
            drive_cycle((col == 5) ? 8'h3C : 8'h00, (col == 5) ? 12'(L + 5) : 12'(col), 1'b1);
        for (int col = 0; col < L; col++) begin
            drive_cycle(8'h00, 12'(col), 1'b1);
            if (col == 5 + LAT) begin
                n_total++;
                if (pd === 8'h3C) n_pass++;
                else $display("FAIL alias pd got=%h exp=3c", pd);
            end
        end
    endtask

    task automatic test_stat_pulses();
        while (!sp_done)
            for (int col = 0; col < L; col++) drive_cycle(8'h00, 12'(col), 1'b1);
        for (int ln = 0; ln < 3; ln++)
            for (int col = 0; col < L; col++) drive_cycle(8'h00, 12'(col), 1'b1);
        n_total++;
        if (pulses_seen == 249 && wq.size() == 0) n_pass++;
        else $display("FAIL pulse_count got=%0d pending=%0d exp=249/0", pulses_seen, wq.size());
        n_total++;
        if (first_out - first_in == 2 * L + LAT) n_pass++;
        else $display("FAIL stat_delay got=%0d exp=%0d", first_out - first_in, 2 * L + LAT);
    endtask

    task automatic test_skip();
        for (int col = 0; col < L; col += 2) drive_cycle(8'h55, 12'(col), 1'b1);
        for (int col = 0; col < L; col++) begin
            drive_cycle(8'h00, 12'(col), 1'b1);
            if (col == 6 + LAT) begin
                n_total++;
                if (pd === 8'h55) n_pass++;
                else $display("FAIL skip_written pd got=%h exp=55", pd);
            end
            if (col == 7 + LAT) begin
                n_total++;
                if (pd === 8'h00) n_pass++;
                else $display("FAIL skip_kept pd got=%h exp=00", pd);
            end
        end
    endtask

    task automatic test_midline_reset();
        for (int ln = 0; ln < 2; ln++)
            for (int col = 0; col < L; col++) begin
                drive_cycle(8'(col) ^ 8'h5A, 12'(col), (ln == 0 && col == 300) ? 1'b0 : 1'b1);
                if (ln == 0 && col == 301) begin
                    n_total++;
                    if (pe === 8'h00 && pd === 8'h00 && pc === 8'h00 && pb === 8'h00 &&
                        pa === 8'h00 && stat_o === 1'b0) n_pass++;
                    else $display("FAIL midline_zero got=%h %h %h %h %h %b exp=all zero",
                                  pa, pb, pc, pd, pe, stat_o);
                end
                if (ln == 1 && col == 400 + LAT) begin
                    n_total++;
                    if (pd === (8'(400) ^ 8'h5A) && pe === (8'(400) ^ 8'h5A)) n_pass++;
                    else $display("FAIL midline_align got pd=%h pe=%h exp=%h", pd, pe, 8'(400) ^ 8'h5A);
                end
            end
    endtask

    initial begin
        for (int i = 0; i < L; i++) begin
            m1[i] = '0; m2[i] = '0; m3[i] = '0; m4[i] = '0; ms1[i] = 1'b0; ms2[i] = 1'b0;
            v1[i] = 1'b1; v2[i] = 1'b1; v3[i] = 1'b1; v4[i] = 1'b1; vs1[i] = 1'b1; vs2[i] = 1'b1;
        end
        test_reset();
        test_ramp();
        test_marker();
        test_alias();
        test_stat_pulses();
        test_skip();
        test_midline_reset();
        for (int i = 0; i < LAT + 1; i++) drive_cycle(8'h00, 12'(i), 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/bram_delay.md
BRAM_DELAY -- requirements
Module: bram_delay

Interface
REQ-001 Parameter DATA_W, default 8: pixel width.
REQ-002 Parameter STAT_W, default 1: status bus width (sync/enable flags).
REQ-003 Parameter ADDR_W, default 12: width of the addr port.
REQ-004 Parameter LINE_LEN, default 1024: line-buffer depth; power of two; memory indexed by addr[log2(LINE_LEN)-1:0].
REQ-005 clk  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-007 data_in  input  DATA_W  incoming pixel of the current line.
REQ-008 stat_in  input  STAT_W  status bits accompanying data_in.
REQ-009 addr  input  ADDR_W  column address, supplied by an external counter; 0..LINE_LEN-1, wrapping each line.
REQ-010 pa  output  DATA_W  pixel of the same column, 4 lines back (oldest).
REQ-011 pb  output  DATA_W  pixel of the same column, 3 lines back.
REQ-012 pc  output  DATA_W  pixel of the same column, 2 lines back (centre tap).
REQ-013 pd  output  DATA_W  pixel of the same column, 1 line back.
REQ-014 pe  output  DATA_W  current-line pixel, pipeline-delayed only.
REQ-015 stat_o  output  STAT_W  stat_in aligned with the centre tap pc.

Function
REQ-016 Stage 1 SHALL register data_in, stat_in and addr every cycle; there is no enable and no stall.
REQ-017 pe SHALL equal data_in sampled 2 clocks earlier (base latency 2).
REQ-018 There SHALL be four line buffers LB1..LB4, each LINE_LEN entries, with synchronous read-before-write at the registered address.
REQ-019 LB1 SHALL store {pixel, status}. LB2 SHALL store {pixel, status}. LB3 and LB4 SHALL store the pixel only.
REQ-020 The cascade SHALL be: LB1 writes data_in with stat_in; LB2 writes LB1's read data; LB3 writes LB2's pixel; LB4 writes LB3's pixel.
REQ-021 For an input sampled at column A: pd/pc/pb/pa SHALL equal the pixel previously written at A in LB1/LB2/LB3/LB4, presented in the same cycle as pe.
REQ-022 stat_o SHALL be the status read from LB2 at A. With a regular addr period of LINE_LEN, stat_o equals stat_in delayed by 2*LINE_LEN+2 clocks.
REQ-023 The line delay SHALL follow the addr pattern, not a cycle count. A repeated addr value overwrites that column; a skipped column keeps its old content.
REQ-024 addr bits above log2(LINE_LEN) SHALL be ignored, so addr values of LINE_LEN and above alias modulo LINE_LEN.
REQ-025 Memory contents SHALL initialise to 0 at configuration; memory writes continue every cycle, including during reset.
REQ-026 All outputs SHALL be registered; there are no combinational input-to-output paths.

Reset
REQ-027 While rst=0 at a clock edge, pa..pe, stat_o and all pipeline registers SHALL become 0.
REQ-028 Reset SHALL NOT clear memory contents.
REQ-029 After rst returns to 1, pe SHALL show valid data from the 2nd edge on; older taps SHALL show memory content.
REQ-030 Reset asserted mid-line SHALL zero the outputs within the same edge and SHALL NOT corrupt the delay alignment after release.

Configuration
REQ-031 Macro BRAM_DELAY_OUTREG_EN, when defined, SHALL add one extra register stage on pa..pe and stat_o: latency 3, all taps shifted equally, reset value 0.
REQ-032 When BRAM_DELAY_OUTREG_EN is undefined, latency SHALL be 2 as specified above.

Verification
REQ-033 Ramp data_in (+1 per clk, 8-bit wrap), addr 0..1023 cycling, reset 1 clk -> pe = data_in 2 clks earlier; after 4 lines, pa=pb=pc=pd=pe (1024 mod 256 = 0).
REQ-034 Marker data_in=0xA5 at addr=17 on line 0, other data 0 -> pe=0xA5 at line 0, pd at line 1, pc at line 2, pb at line 3, pa at line 4, each at column 17 and +2 clks.
REQ-035 stat_in pulses of width 2,4,6,..,498 clks -> stat_o reproduces each pulse width exactly, delayed 2*1024+2 clks.
REQ-036 rst=0 for 1 clk mid-line -> all outputs 0 the next cycle; column alignment of pa..pe and stat_o intact on the next line.
REQ-037 addr=1024+5 with data_in=0x3C -> 0x3C is read back one line later at column 5 on pd.
REQ-038 With BRAM_DELAY_OUTREG_EN defined, rerun REQ-033 -> pe = data_in delayed 3 clks; tap relationships unchanged.
